// File: rtl/switch_debounce.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, stability-counter
// debounce, registered release pulses. SWITCH_DEBOUNCE_PRESS_EN adds press pulses.

module switch_debounce_lane #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_WIDTH      = 18
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Pin,
  output logic o_Level,
  output logic o_Release,
  output logic o_Press
);
  localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);

  logic                 meta_q, meta_d;
  logic                 sync_q, sync_d;
  logic                 level_q, level_d;
  logic                 rel_q, rel_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef SWITCH_DEBOUNCE_PRESS_EN
  logic                 prs_q, prs_d;
`endif

  // Any agreeing sample drops the count back to zero: no partial credit.
  always_comb begin
    meta_d  = i_Pin;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = '0;
    rel_d   = 1'b0;
`ifdef SWITCH_DEBOUNCE_PRESS_EN
    prs_d   = 1'b0;
`endif
    if (sync_q != level_q) begin
      if (cnt_q == LIMIT_M1) begin
        level_d = sync_q;
        rel_d   = ~sync_q;
`ifdef SWITCH_DEBOUNCE_PRESS_EN
        prs_d   = sync_q;
`endif
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_PRESS_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset) prs_q <= 1'b0;
    else         prs_q <= prs_d;
  end
  assign o_Press = prs_q;
`else
  assign o_Press = 1'b0;
`endif

  assign o_Level   = level_q;
  assign o_Release = rel_q;
endmodule

module switch_debounce #(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_WIDTH      = 18
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_Press
);
  for (genvar g = 0; g < NUM_SW; g++) begin : g_lane
    switch_debounce_lane #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_lane (
      .i_Clk    (i_Clk),
      .i_Reset  (i_Reset),
      .i_Pin    (i_Switch[g]),
      .o_Level  (o_Switch[g]),
      .o_Release(o_Release[g]),
      .o_Press  (o_Press[g])
    );
  end
endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboarded random + directed bench for switch_debounce; reference model
// accepts a level when the last LIMIT synchronised samples all disagree with it.

module tb_switch_debounce;
  localparam int NSW = 4;
  localparam int L   = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NSW-1:0] sw;
  logic [NSW-1:0] o_sw, o_rel, o_prs;

  switch_debounce #(.NUM_SW(NSW), .DEBOUNCE_LIMIT(L), .CNT_WIDTH(CW)) dut (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .i_Switch (sw),
    .o_Switch (o_sw),
    .o_Release(o_rel),
    .o_Press  (o_prs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NSW-1:0] lvl;
    logic [NSW-1:0] rel;
    logic [NSW-1:0] prs;
  } exp_t;

  exp_t           exp_q[$];
  int             errors = 0;
  int             checks = 0;
  int             cyc    = 0;

  logic [NSW-1:0] m_o;
  logic [NSW-1:0] pin_hist[$];  // raw pin samples, last two edges
  logic [NSW-1:0] s_hist[$];    // synchronised values seen by the filter, last L edges
  logic [NSW-1:0] cur;

  task automatic model_edge(input logic r, input logic [NSW-1:0] p);
    exp_t           e;
    logic [NSW-1:0] s_now;
    logic           all_diff;
    e = '0;
    if (r) begin
      pin_hist.delete();
      s_hist.delete();
      m_o = '0;
    end else begin
      s_now = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size()-2] : '0;
      pin_hist.push_back(p);
      if (pin_hist.size() > 2) void'(pin_hist.pop_front());
      s_hist.push_back(s_now);
      if (s_hist.size() > L) void'(s_hist.pop_front());
      for (int ch = 0; ch < NSW; ch++) begin
        if (s_hist.size() == L) begin
          all_diff = 1'b1;
          foreach (s_hist[i]) if (s_hist[i][ch] == m_o[ch]) all_diff = 1'b0;
          if (all_diff) begin
            m_o[ch] = ~m_o[ch];
            if (m_o[ch]) e.prs[ch] = 1'b1;
            else         e.rel[ch] = 1'b1;
          end
        end
      end
    end
`ifndef SWITCH_DEBOUNCE_PRESS_EN
    e.prs = '0;
`endif
    e.lvl = m_o;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [NSW-1:0] p);
    rst = r;
    sw  = p;
    @(posedge clk);
    cyc++;
    model_edge(r, p);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur);
  endtask

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (o_sw !== e.lvl) begin
        errors++;
        $display("FAIL o_Switch cyc=%0d got=%b exp=%b", cyc, o_sw, e.lvl);
      end
      checks++;
      if (o_rel !== e.rel) begin
        errors++;
        $display("FAIL o_Release cyc=%0d got=%b exp=%b", cyc, o_rel, e.rel);
      end
      checks++;
      if (o_prs !== e.prs) begin
        errors++;
        $display("FAIL o_Press cyc=%0d got=%b exp=%b", cyc, o_prs, e.prs);
      end
    end
  end

  initial begin
    logic [9:0] bounce;
    int         guard;
    m_o    = '0;
    bounce = 10'b11111_01101;  // applied LSB first: 1,0,1,1,0,1,1,1,1,1

    // Pins high through reset, then released.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111);
    cur = 4'b1111;
    hold(10);

    // Clean press/release on ch0.
    step(1'b1, '0);
    cur = 4'b0001; hold(10);
    cur = 4'b0000; hold(10);

    // Bounce on ch1.
    for (int i = 0; i < 10; i++) begin
      cur[1] = bounce[i];
      hold(1);
    end
    hold(6);

    // Short glitch on ch2 while it reads high.
    cur[2] = 1'b1; hold(8);
    cur[2] = 1'b0; hold(3);
    cur[2] = 1'b1; hold(8);

    // Simultaneous release on ch0 and ch3.
    cur = 4'b1111; hold(8);
    cur = 4'b0110; hold(8);

    // Reset partway through a 0->1 count on ch3.
    cur[3] = 1'b1; hold(2);
    step(1'b1, cur);
    hold(8);

    // Random bouncy pins with occasional reset.
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < NSW; ch++)
        if ($urandom_range(5) == 0) cur[ch] = ~cur[ch];
      step($urandom_range(149) == 0, cur);
    end
    // Long stable stretch so every channel settles.
    hold(10);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
